// File: rtl/intr_flag_sequencer_pkg.sv
// Shared types and constants for the interrupt entry/exit sequencer.
// Includes the state encoding, widths, the default vector address and the stack pointer helpers.
package intr_flag_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    localparam logic [DATA_W-1:0] VEC_ADDR_DEF = 8'h00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        PUSH    = 3'd2,
        VREQ    = 3'd3,
        VLOAD   = 3'd4,
        RTI_POP = 3'd5,
        RTI_LD  = 3'd6
    } state_e;

    // Stack grows down; both directions wrap modulo 256.
    function automatic logic [DATA_W-1:0] sp_dec(input logic [DATA_W-1:0] sp);
        return sp - 8'd1;
    endfunction

    function automatic logic [DATA_W-1:0] sp_inc(input logic [DATA_W-1:0] sp);
        return sp + 8'd1;
    endfunction

endpackage

// File: rtl/intr_flag_sequencer_edge_pend.sv
// INTR rising-edge detector and one-deep pending latch.
// A new edge is dropped while a request is already pending; accepting the request clears it.
module intr_edge_pend
    import intr_flag_sequencer_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic intr,
    input  logic accept,
    output logic pending
);

    logic intr_d_r;
    logic pending_r;
    logic edge_s;

    assign edge_s  = intr & ~intr_d_r;
    assign pending = pending_r;

    // Edge register and pending latch; accepting wins over a coincident edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            intr_d_r  <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            intr_d_r <= intr;
            if (accept) begin
                pending_r <= 1'b0;
            end else if (edge_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

endmodule

// File: rtl/intr_flag_sequencer.sv
// Interrupt entry/exit sequencer: drains the pipe, pushes the return PC, loads the ISR vector and pulses F_Save.
// On RTI it pops the PC and pulses F_Restore. Interrupts are single-level only.
module intr_flag_sequencer
    import intr_flag_sequencer_pkg::*;
#(
    parameter int                DRAIN_CYCLES = 3,
    parameter logic [DATA_W-1:0] VEC_ADDR     = VEC_ADDR_DEF
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              INTR,
    input  logic              RTI_EXEC,
    input  logic [DATA_W-1:0] PC_CUR,
    input  logic [DATA_W-1:0] SP_CUR,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              STALL,
    output logic              FLUSH,
    output logic              F_Save,
    output logic              F_Restore,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    output logic              MEM_RE,
    output logic [DATA_W-1:0] SP_NEXT,
    output logic              SP_WE,
    output logic [DATA_W-1:0] PC_NEXT,
    output logic              PC_WE,
    output logic              IN_ISR
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_e             state_r;
    state_e             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               in_isr_r;
    logic               in_isr_s;
    logic               accept_s;
    logic               pending_s;

    intr_edge_pend u_edge_pend (
        .CLK     (CLK),
        .RST     (RST),
        .intr    (INTR),
        .accept  (accept_s),
        .pending (pending_s)
    );

    assign IN_ISR = in_isr_r;

    // State, drain counter and in-service flag registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            in_isr_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            in_isr_r <= in_isr_s;
        end
    end

    // Next-state logic; RTI outranks a pending interrupt in IDLE.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        in_isr_s = in_isr_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (RTI_EXEC && in_isr_r) begin
                    state_s = RTI_POP;
                end else if (pending_s && !in_isr_r) begin
                    state_s  = DRAIN;
                    cnt_s    = CNT_LOAD;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = PUSH;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            PUSH:    state_s = VREQ;
            VREQ:    state_s = VLOAD;
            VLOAD: begin
                state_s  = IDLE;
                in_isr_s = 1'b1;
            end
            RTI_POP: state_s = RTI_LD;
            RTI_LD: begin
                state_s  = IDLE;
                in_isr_s = 1'b0;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Moore output decode; buses stay 0 in states that do not drive them.
    always_comb begin
        STALL     = 1'b0;
        FLUSH     = 1'b0;
        F_Save    = 1'b0;
        F_Restore = 1'b0;
        MEM_ADDR  = 8'h00;
        MEM_WDATA = 8'h00;
        MEM_WE    = 1'b0;
        MEM_RE    = 1'b0;
        SP_NEXT   = 8'h00;
        SP_WE     = 1'b0;
        PC_NEXT   = 8'h00;
        PC_WE     = 1'b0;
        case (state_r)
            DRAIN: begin
                STALL = 1'b1;
            end
            PUSH: begin
                STALL     = 1'b1;
                MEM_WE    = 1'b1;
                MEM_ADDR  = SP_CUR;
                MEM_WDATA = PC_CUR;
                SP_WE     = 1'b1;
                SP_NEXT   = sp_dec(SP_CUR);
                F_Save    = 1'b1;
            end
            VREQ: begin
                STALL    = 1'b1;
                MEM_RE   = 1'b1;
                MEM_ADDR = VEC_ADDR;
            end
            VLOAD: begin
                STALL   = 1'b1;
                PC_WE   = 1'b1;
                PC_NEXT = MEM_RDATA;
                FLUSH   = 1'b1;
            end
            RTI_POP: begin
                STALL    = 1'b1;
                MEM_RE   = 1'b1;
                MEM_ADDR = sp_inc(SP_CUR);
                SP_WE    = 1'b1;
                SP_NEXT  = sp_inc(SP_CUR);
            end
            RTI_LD: begin
                STALL     = 1'b1;
                PC_WE     = 1'b1;
                PC_NEXT   = MEM_RDATA;
                FLUSH     = 1'b1;
                F_Restore = 1'b1;
            end
            default: begin
                STALL = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_intr_flag_sequencer.sv
// Directed bench for intr_flag_sequencer: per-cycle vector table for entry/return/wrap/stray RTI,
// then hand-written sequences for interrupt-during-ISR, RTI/pending priority and reset mid-drain.
module tb_intr_flag_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       INTR = 1'b0;
    logic       RTI_EXEC = 1'b0;
    logic [7:0] PC_CUR = 8'h00;
    logic [7:0] SP_CUR = 8'h00;
    logic [7:0] MEM_RDATA = 8'h00;
    logic       STALL, FLUSH, F_Save, F_Restore, MEM_WE, MEM_RE, SP_WE, PC_WE, IN_ISR;
    logic [7:0] MEM_ADDR, MEM_WDATA, SP_NEXT, PC_NEXT;

    intr_flag_sequencer #(.DRAIN_CYCLES(3), .VEC_ADDR(8'h00)) dut (
        .CLK(CLK), .RST(RST), .INTR(INTR), .RTI_EXEC(RTI_EXEC),
        .PC_CUR(PC_CUR), .SP_CUR(SP_CUR), .MEM_RDATA(MEM_RDATA),
        .STALL(STALL), .FLUSH(FLUSH), .F_Save(F_Save), .F_Restore(F_Restore),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_RE(MEM_RE),
        .SP_NEXT(SP_NEXT), .SP_WE(SP_WE), .PC_NEXT(PC_NEXT), .PC_WE(PC_WE), .IN_ISR(IN_ISR)
    );

    always #5 CLK = ~CLK;

    // flags order: stall, flush, fsave, frest, mwe, mre, spwe, pcwe, inisr
    typedef struct packed {
        logic [8:0] flags;
        logic [7:0] maddr;
        logic [7:0] mwdata;
        logic [7:0] spn;
        logic [7:0] pcn;
    } outs_t;

    typedef struct {
        logic       intr;
        logic       rti;
        logic [7:0] pc;
        logic [7:0] sp;
        logic [7:0] rd;
        outs_t      exp;
    } vec_t;

    localparam int NVEC = 24;
    vec_t  tbl [NVEC];
    int    n_vec = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    n_excl = 0;
    int    n_we, n_fs, n_st;
    outs_t act;

    function automatic outs_t o(input logic [8:0] f, input logic [7:0] a, input logic [7:0] w,
                                input logic [7:0] s, input logic [7:0] p);
        return {f, a, w, s, p};
    endfunction

    task automatic add(input logic intr, input logic rti, input logic [7:0] pc, input logic [7:0] sp,
                       input logic [7:0] rd, input outs_t e);
        tbl[n_vec] = '{intr, rti, pc, sp, rd, e};
        n_vec++;
    endtask

    task automatic sample();
        act = {STALL, FLUSH, F_Save, F_Restore, MEM_WE, MEM_RE, SP_WE, PC_WE, IN_ISR,
               MEM_ADDR, MEM_WDATA, SP_NEXT, PC_NEXT};
        n_excl += int'(F_Save & F_Restore);
    endtask

    task automatic cyc(input logic intr, input logic rti, input logic [7:0] pc, input logic [7:0] sp,
                       input logic [7:0] rd);
        @(negedge CLK);
        INTR = intr; RTI_EXEC = rti; PC_CUR = pc; SP_CUR = sp; MEM_RDATA = rd;
        #1;
        sample();
    endtask

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0; INTR = 1'b0; RTI_EXEC = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        // Table: basic entry, return, stray RTI, entry with SP wrap.
        add(1'b0, 1'b0, 8'h42, 8'hFF, 8'h00, o(9'b000000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b1, 1'b0, 8'h42, 8'hFF, 8'h00, o(9'b000000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h42, 8'hFF, 8'h00, o(9'b000000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h42, 8'hFF, 8'h00, o(9'b100000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h42, 8'hFF, 8'h00, o(9'b100000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h42, 8'hFF, 8'h00, o(9'b100000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h42, 8'hFF, 8'h00, o(9'b101010100, 8'hFF, 8'h42, 8'hFE, 8'h00));
        add(1'b0, 1'b0, 8'h42, 8'hFE, 8'h80, o(9'b100001000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h42, 8'hFE, 8'h80, o(9'b110000010, 8'h00, 8'h00, 8'h00, 8'h80));
        add(1'b0, 1'b1, 8'h81, 8'hFE, 8'h00, o(9'b000000001, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h81, 8'hFE, 8'h00, o(9'b100001101, 8'hFF, 8'h00, 8'hFF, 8'h00));
        add(1'b0, 1'b0, 8'h81, 8'hFF, 8'h42, o(9'b110100011, 8'h00, 8'h00, 8'h00, 8'h42));
        add(1'b0, 1'b0, 8'h42, 8'hFF, 8'h00, o(9'b000000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b1, 8'h42, 8'hFF, 8'h00, o(9'b000000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h42, 8'hFF, 8'h00, o(9'b000000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b1, 1'b0, 8'h5A, 8'h00, 8'h00, o(9'b000000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h5A, 8'h00, 8'h00, o(9'b000000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h5A, 8'h00, 8'h00, o(9'b100000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h5A, 8'h00, 8'h00, o(9'b100000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h5A, 8'h00, 8'h00, o(9'b100000000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h5A, 8'h00, 8'h00, o(9'b101010100, 8'h00, 8'h5A, 8'hFF, 8'h00));
        add(1'b0, 1'b0, 8'h5A, 8'hFF, 8'hC3, o(9'b100001000, 8'h00, 8'h00, 8'h00, 8'h00));
        add(1'b0, 1'b0, 8'h5A, 8'hFF, 8'hC3, o(9'b110000010, 8'h00, 8'h00, 8'h00, 8'hC3));
        add(1'b0, 1'b0, 8'h5A, 8'hFF, 8'h00, o(9'b000000001, 8'h00, 8'h00, 8'h00, 8'h00));

        #2;
        sample();
        chk("reset_outputs", 64'(act), 64'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            cyc(tbl[i].intr, tbl[i].rti, tbl[i].pc, tbl[i].sp, tbl[i].rd);
            chk($sformatf("vec%0d", i), 64'(act), 64'(tbl[i].exp));
        end

        // Interrupt during ISR, third edge lost, RTI beats pending.
        do_reset();
        cyc(1'b1, 1'b0, 8'h42, 8'hFF, 8'h80);
        cyc(1'b0, 1'b0, 8'h42, 8'hFF, 8'h80);
        n_we = 0; n_fs = 0;
        repeat (8) begin
            cyc(1'b0, 1'b0, 8'h42, 8'hFF, 8'h80);
            n_we += int'(act.flags[4]);
            n_fs += int'(act.flags[6]);
        end
        chk("entry_push_count", 64'(n_we), 64'd1);
        chk("entry_fsave_count", 64'(n_fs), 64'd1);
        chk("entry_in_isr", 64'(act.flags[0]), 64'd1);
        cyc(1'b1, 1'b0, 8'h42, 8'hFE, 8'h80);
        cyc(1'b0, 1'b0, 8'h42, 8'hFE, 8'h80);
        n_st = 0;
        repeat (5) begin
            cyc(1'b0, 1'b0, 8'h42, 8'hFE, 8'h80);
            n_st += int'(act.flags[8]);
        end
        chk("no_entry_in_isr", 64'(n_st), 64'd0);
        cyc(1'b1, 1'b0, 8'h42, 8'hFE, 8'h80);
        cyc(1'b0, 1'b0, 8'h42, 8'hFE, 8'h80);
        cyc(1'b0, 1'b1, 8'h90, 8'hFE, 8'h80);
        cyc(1'b0, 1'b0, 8'h90, 8'hFE, 8'h80);
        chk("simul_rti_pop_first", 64'({act.flags[3], act.flags[2], act.flags[4], act.flags[6], act.maddr}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 8'hFF}));
        cyc(1'b0, 1'b0, 8'h90, 8'hFF, 8'h42);
        chk("simul_rti_ld", 64'({act.flags[5], act.flags[1], act.pcn}), 64'({1'b1, 1'b1, 8'h42}));
        cyc(1'b0, 1'b0, 8'h42, 8'hFF, 8'h80);
        chk("post_rti_idle", 64'({act.flags[8], act.flags[0]}), 64'd0);
        cyc(1'b0, 1'b0, 8'h42, 8'hFF, 8'h80);
        chk("pending_entry_starts", 64'(act.flags[8]), 64'd1);
        n_we = 0; n_fs = 0;
        repeat (10) begin
            cyc(1'b0, 1'b0, 8'h42, 8'hFF, 8'h80);
            n_we += int'(act.flags[4]);
            n_fs += int'(act.flags[6]);
        end
        chk("pending_one_push", 64'(n_we), 64'd1);
        chk("pending_one_fsave", 64'(n_fs), 64'd1);
        chk("pending_in_isr", 64'(act.flags[0]), 64'd1);
        cyc(1'b0, 1'b1, 8'h80, 8'hFE, 8'h00);
        cyc(1'b0, 1'b0, 8'h80, 8'hFE, 8'h00);
        cyc(1'b0, 1'b0, 8'h80, 8'hFF, 8'h42);
        n_st = 0;
        repeat (20) begin
            cyc(1'b0, 1'b0, 8'h42, 8'hFF, 8'h80);
            n_st += int'(act.flags[8]);
        end
        chk("third_edge_lost", 64'(n_st), 64'd0);
        chk("final_in_isr", 64'(act.flags[0]), 64'd0);

        // Reset asserted in the second drain cycle.
        do_reset();
        cyc(1'b1, 1'b0, 8'h42, 8'hFF, 8'h80);
        cyc(1'b0, 1'b0, 8'h42, 8'hFF, 8'h80);
        cyc(1'b0, 1'b0, 8'h42, 8'hFF, 8'h80);
        chk("drain1_stall", 64'(act.flags[8]), 64'd1);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        sample();
        chk("reset_mid_drain_outputs", 64'(act), 64'h0);
        @(negedge CLK);
        RST = 1'b1;
        n_we = 0; n_fs = 0; n_st = 0;
        repeat (15) begin
            cyc(1'b0, 1'b0, 8'h42, 8'hFF, 8'h80);
            n_we += int'(act.flags[4]);
            n_fs += int'(act.flags[6]);
            n_st += int'(act.flags[8]);
        end
        chk("after_reset_no_push", 64'(n_we), 64'd0);
        chk("after_reset_no_fsave", 64'(n_fs), 64'd0);
        chk("after_reset_pending_cleared", 64'(n_st), 64'd0);
        chk("fsave_frest_exclusive", 64'(n_excl), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
